// File: rtl/fetch_pc_pkg.sv
// Shared definitions for the fetch PC / IF-ID stage: state encoding,
// exception vector table placement and cause width.
package fetch_pc_pkg;

  localparam int unsigned CAUSE_W    = 4;
  localparam int unsigned NUM_CAUSES = 16;

  // Word index of vector 0 (mips.h IVT_BOT); the byte address is this shifted by two.
  localparam logic [31:0] IVT_BOT  = 32'h0000_0020;
  localparam logic [31:0] IVT_BASE = IVT_BOT << 2;

  typedef enum logic [1:0] {
    FETCH_BOOT  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_FAULT = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] vector_addr(input logic [31:0] base,
                                              input logic [CAUSE_W-1:0] cause);
    return base + {26'd0, cause, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_if.sv
// Bundle of the fetch stage's memory, redirect and IF/ID signals.
// master = fetch unit side, slave = memory / pipeline side.
interface fetch_pc_if;
  import fetch_pc_pkg::*;

  logic [31:0]        start_addr;
  logic [31:0]        fetch_addr;
  logic [31:0]        mem_instruction;
  logic               stall;
  logic               branch_valid;
  logic [31:0]        branch_target;
  logic               eret_valid;
  logic               exc_valid;
  logic [CAUSE_W-1:0] exc_cause;
  logic [31:0]        exc_pc;
  logic               if_id_valid;
  logic [31:0]        if_id_instr;
  logic [31:0]        if_id_pc;
  logic [31:0]        if_id_pc_plus4;
  logic [31:0]        epc;
  logic               fetch_fault;

  modport master (
    input  start_addr, mem_instruction, stall, branch_valid, branch_target,
           eret_valid, exc_valid, exc_cause, exc_pc,
    output fetch_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4,
           epc, fetch_fault
  );

  modport slave (
    output start_addr, mem_instruction, stall, branch_valid, branch_target,
           eret_valid, exc_valid, exc_cause, exc_pc,
    input  fetch_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4,
           epc, fetch_fault
  );

endinterface

// File: rtl/fetch_pc_next_pc_sel.sv
// Combinational next-PC priority mux for the RUN state:
// exception > eret > branch > stall > sequential.
module next_pc_sel
  import fetch_pc_pkg::*;
#(
  parameter logic [31:0] IVT_BASE_P = IVT_BASE
) (
  input  logic [31:0]        pc,
  input  logic [31:0]        epc,
  input  logic               stall,
  input  logic               branch_valid,
  input  logic [31:0]        branch_target,
  input  logic               eret_valid,
  input  logic               exc_valid,
  input  logic [CAUSE_W-1:0] exc_cause,
  output logic [31:0]        pc_next,
  output logic               epc_we,
  output logic               squash,
  output logic               load_ifid,
  output logic               misalign
);

  logic [31:0] target_s;

  always_comb begin
    target_s  = pc;
    epc_we    = 1'b0;
    squash    = 1'b0;
    load_ifid = 1'b0;
    pc_next   = pc;
    misalign  = 1'b0;

    if (exc_valid) begin
      target_s = vector_addr(IVT_BASE_P, exc_cause);
      epc_we   = 1'b1;
      squash   = 1'b1;
    end else if (eret_valid) begin
      // Registered epc: an eret never sees a same-cycle exception's write.
      target_s = epc;
      squash   = 1'b1;
    end else if (branch_valid) begin
      target_s = branch_target;
      squash   = 1'b1;
    end else if (stall) begin
      pc_next = pc;
    end else begin
      load_ifid = 1'b1;
      pc_next   = pc + 32'd4;
    end

    if (squash) begin
      pc_next  = {target_s[31:2], 2'b00};
      misalign = (target_s[1:0] != 2'b00);
    end else begin
      misalign = 1'b0;
    end
  end

endmodule

// File: rtl/fetch_pc.sv
// Program counter and IF/ID register ahead of a zero-latency instruction
// memory; boots from the memory-supplied start address.
module fetch_pc
  import fetch_pc_pkg::*;
#(
  parameter logic [31:0] IVT_BASE_P = IVT_BASE
) (
  input  logic       clock,
  input  logic       reset_n,
  fetch_pc_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  epc_q, epc_d;
  logic         valid_q, valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  ifpc_q, ifpc_d;
  logic [31:0]  ifpc4_q, ifpc4_d;
  logic         fault_q, fault_d;

  logic [31:0]  sel_pc_next_s;
  logic         sel_epc_we_s;
  logic         sel_squash_s;
  logic         sel_load_s;
  logic         sel_misalign_s;

  next_pc_sel #(.IVT_BASE_P(IVT_BASE_P)) u_sel (
    .pc            (pc_q),
    .epc           (epc_q),
    .stall         (bus.stall),
    .branch_valid  (bus.branch_valid),
    .branch_target (bus.branch_target),
    .eret_valid    (bus.eret_valid),
    .exc_valid     (bus.exc_valid),
    .exc_cause     (bus.exc_cause),
    .pc_next       (sel_pc_next_s),
    .epc_we        (sel_epc_we_s),
    .squash        (sel_squash_s),
    .load_ifid     (sel_load_s),
    .misalign      (sel_misalign_s)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    ifpc4_d = ifpc4_q;
    fault_d = fault_q;

    case (state_q)
      FETCH_BOOT: begin
        pc_d    = {bus.start_addr[31:2], 2'b00};
        valid_d = 1'b0;
        state_d = FETCH_RUN;
      end
      FETCH_RUN: begin
        pc_d = sel_pc_next_s;
        if (sel_epc_we_s) begin
          epc_d = bus.exc_pc;
        end else begin
          epc_d = epc_q;
        end
        // Squash clears only valid; stale instr/pc are left in place.
        if (sel_squash_s) begin
          valid_d = 1'b0;
        end else if (sel_load_s) begin
          valid_d = 1'b1;
          instr_d = bus.mem_instruction;
          ifpc_d  = pc_q;
          ifpc4_d = pc_q + 32'd4;
        end else begin
          valid_d = valid_q;
        end
        if (sel_misalign_s) begin
          fault_d = 1'b1;
          state_d = FETCH_FAULT;
        end else begin
          state_d = FETCH_RUN;
        end
      end
      FETCH_FAULT: begin
        valid_d = 1'b0;
      end
      default: begin
        valid_d = 1'b0;
        fault_d = 1'b1;
        state_d = FETCH_FAULT;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH_BOOT;
      pc_q    <= 32'd0;
      epc_q   <= 32'd0;
      valid_q <= 1'b0;
      instr_q <= 32'd0;
      ifpc_q  <= 32'd0;
      ifpc4_q <= 32'd4;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      ifpc4_q <= ifpc4_d;
      fault_q <= fault_d;
    end
  end

  assign bus.fetch_addr     = pc_q;
  assign bus.if_id_valid    = valid_q;
  assign bus.if_id_instr    = instr_q;
  assign bus.if_id_pc       = ifpc_q;
  assign bus.if_id_pc_plus4 = ifpc4_q;
  assign bus.epc            = epc_q;
  assign bus.fetch_fault    = fault_q;

endmodule

// File: tb/tb_fetch_pc.sv
// Directed self-checking bench for fetch_pc; memory returns ~address.
module tb_fetch_pc;
  import fetch_pc_pkg::*;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_pass;

  fetch_pc_if bus();

  fetch_pc dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  assign bus.mem_instruction = ~bus.fetch_addr;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall         = 1'b0;
    bus.branch_valid  = 1'b0;
    bus.branch_target = 32'd0;
    bus.eret_valid    = 1'b0;
    bus.exc_valid     = 1'b0;
    bus.exc_cause     = 4'd0;
    bus.exc_pc        = 32'd0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    bus.start_addr = 32'h0040_0000;
    idle_inputs();

    // Reset state
    step();
    step();
    chk("rst_fetch_addr", bus.fetch_addr, 32'h0);
    chk("rst_valid", {31'd0, bus.if_id_valid}, 32'd0);
    chk("rst_if_instr", bus.if_id_instr, 32'h0);
    chk("rst_if_pc", bus.if_id_pc, 32'h0);
    chk("rst_if_pc4", bus.if_id_pc_plus4, 32'h4);
    chk("rst_epc", bus.epc, 32'h0);
    chk("rst_fault", {31'd0, bus.fetch_fault}, 32'd0);

    // Boot
    reset_n = 1'b1;
    chk("boot_c1_addr", bus.fetch_addr, 32'h0);
    step();
    chk("boot_c2_addr", bus.fetch_addr, 32'h0040_0000);
    chk("boot_c2_valid", {31'd0, bus.if_id_valid}, 32'd0);
    step();
    chk("first_if_pc", bus.if_id_pc, 32'h0040_0000);
    chk("first_valid", {31'd0, bus.if_id_valid}, 32'd1);
    chk("first_instr", bus.if_id_instr, ~32'h0040_0000);
    chk("first_pc4", bus.if_id_pc_plus4, 32'h0040_0004);
    chk("first_addr", bus.fetch_addr, 32'h0040_0004);

    // Two more free cycles, then stall for two
    step();
    step();
    chk("seq_addr", bus.fetch_addr, 32'h0040_000C);
    chk("seq_if_pc", bus.if_id_pc, 32'h0040_0008);
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_addr", bus.fetch_addr, 32'h0040_000C);
      chk("stall_if_pc", bus.if_id_pc, 32'h0040_0008);
      chk("stall_valid", {31'd0, bus.if_id_valid}, 32'd1);
    end
    bus.stall = 1'b0;
    step();
    chk("resume_if_pc", bus.if_id_pc, 32'h0040_000C);
    chk("resume_instr", bus.if_id_instr, ~32'h0040_000C);
    chk("resume_addr", bus.fetch_addr, 32'h0040_0010);

    // Branch overrides stall
    bus.stall         = 1'b1;
    bus.branch_valid  = 1'b1;
    bus.branch_target = 32'h0040_0100;
    step();
    chk("br_addr", bus.fetch_addr, 32'h0040_0100);
    chk("br_valid", {31'd0, bus.if_id_valid}, 32'd0);
    idle_inputs();
    step();
    chk("br_if_pc", bus.if_id_pc, 32'h0040_0100);
    chk("br_if_valid", {31'd0, bus.if_id_valid}, 32'd1);

    // Exception beats eret and branch in the same cycle
    bus.exc_valid     = 1'b1;
    bus.eret_valid    = 1'b1;
    bus.branch_valid  = 1'b1;
    bus.branch_target = 32'h0040_0300;
    bus.exc_cause     = 4'd3;
    bus.exc_pc        = 32'h0040_0020;
    step();
    chk("exc_addr", bus.fetch_addr, IVT_BASE + 32'h0000_000C);
    chk("exc_epc", bus.epc, 32'h0040_0020);
    chk("exc_valid", {31'd0, bus.if_id_valid}, 32'd0);
    idle_inputs();
    step();
    chk("vec_if_pc", bus.if_id_pc, IVT_BASE + 32'h0000_000C);
    bus.eret_valid = 1'b1;
    step();
    chk("eret_addr", bus.fetch_addr, 32'h0040_0020);
    chk("eret_valid", {31'd0, bus.if_id_valid}, 32'd0);
    idle_inputs();

    // Wrap past the top of the address space
    bus.branch_valid  = 1'b1;
    bus.branch_target = 32'hFFFF_FFFC;
    step();
    chk("wrap_br_addr", bus.fetch_addr, 32'hFFFF_FFFC);
    idle_inputs();
    step();
    chk("wrap_addr", bus.fetch_addr, 32'h0);
    chk("wrap_if_pc", bus.if_id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", bus.if_id_pc_plus4, 32'h0);
    chk("wrap_fault", {31'd0, bus.fetch_fault}, 32'd0);

    // Misaligned branch target faults, then everything is ignored
    bus.branch_valid  = 1'b1;
    bus.branch_target = 32'h0040_0102;
    step();
    chk("mis_fault", {31'd0, bus.fetch_fault}, 32'd1);
    chk("mis_addr", bus.fetch_addr, 32'h0040_0100);
    chk("mis_valid", {31'd0, bus.if_id_valid}, 32'd0);
    bus.branch_target = 32'h0040_0200;
    bus.exc_valid     = 1'b1;
    bus.exc_pc        = 32'h1234_5678;
    step();
    idle_inputs();
    step();
    chk("flt_addr", bus.fetch_addr, 32'h0040_0100);
    chk("flt_valid", {31'd0, bus.if_id_valid}, 32'd0);
    chk("flt_epc", bus.epc, 32'h0040_0020);
    chk("flt_sticky", {31'd0, bus.fetch_fault}, 32'd1);

    // Asynchronous reset clears the fault without a clock edge
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_fault", {31'd0, bus.fetch_fault}, 32'd0);
    chk("arst_addr", bus.fetch_addr, 32'h0);
    chk("arst_epc", bus.epc, 32'h0);
    bus.start_addr = 32'h0040_0003;
    step();
    reset_n = 1'b1;
    step();
    chk("reboot_addr", bus.fetch_addr, 32'h0040_0000);

    // Eret to a misaligned saved epc faults
    bus.exc_valid = 1'b1;
    bus.exc_cause = 4'd15;
    bus.exc_pc    = 32'h0040_0022;
    step();
    chk("exc15_addr", bus.fetch_addr, IVT_BASE + 32'h0000_003C);
    chk("exc15_fault", {31'd0, bus.fetch_fault}, 32'd0);
    idle_inputs();
    bus.eret_valid = 1'b1;
    step();
    idle_inputs();
    chk("eret_mis_fault", {31'd0, bus.fetch_fault}, 32'd1);
    chk("eret_mis_addr", bus.fetch_addr, 32'h0040_0020);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_pc.md
Name: fetch_pc

Overview:
- Program-counter and IF/ID register stage directly upstream of the instruction memory.
- Drives the memory read address and boots from the memory-supplied start address.
- Sequences PC+4, branch, exception (IVT) and eret redirects.
- Latches the returned instruction with its PC into the IF/ID register for decode.

Parameters:
- IVT_BASE, `IVT_BOT << 2` (mips.h): byte address of exception vector 0.
- NUM_CAUSES, 16: number of exception vectors; each vector is one word, at IVT_BASE + 4*cause.

Ports:
- clock  in  1  system clock, all state updates on posedge
- reset_n  in  1  asynchronous active-low reset
- start_addr  in  32  boot PC from instruction memory (word-aligned by memory)
- fetch_addr  out  32  byte address to instruction memory readAddress
- mem_instruction  in  32  instruction word at fetch_addr (combinational from memory)
- stall  in  1  decode backpressure; hold PC and IF/ID
- branch_valid  in  1  redirect to branch_target
- branch_target  in  32  byte address
- eret_valid  in  1  return to epc
- exc_valid  in  1  take exception
- exc_cause  in  4  vector index, less than NUM_CAUSES
- exc_pc  in  32  PC of the faulting instruction
- if_id_valid  out  1  IF/ID holds a live instruction
- if_id_instr  out  32  latched instruction
- if_id_pc  out  32  PC of if_id_instr
- if_id_pc_plus4  out  32  if_id_pc + 4, modulo 2^32
- epc  out  32  saved exception PC
- fetch_fault  out  1  sticky: misaligned redirect target taken

Behaviour:
- Reset (asynchronous, while reset_n=0), all outputs:
  - state=BOOT, pc=0, fetch_addr=0.
  - if_id_valid=0, if_id_instr=0, if_id_pc=0, if_id_pc_plus4=4.
  - epc=0, fetch_fault=0.
  - Reset asserted mid-operation aborts everything immediately.
- fetch_addr = pc, combinational. Instruction-memory latency is zero; IF/ID adds one cycle.
- States:
  - BOOT: memory output not yet valid; if_id_valid stays 0; all redirect, stall and exception inputs are ignored. At the first posedge after reset release: pc <= start_addr & ~3, go to RUN.
  - RUN: at each posedge, evaluate in priority order; first match wins:
    1. exc_valid: epc <= exc_pc; pc <= IVT_BASE + {exc_cause,2'b00}; if_id_valid <= 0.
    2. eret_valid: pc <= epc (the registered value, pre-update); if_id_valid <= 0.
    3. branch_valid: pc <= branch_target; if_id_valid <= 0.
    4. stall: pc, IF/ID and epc all held.
    5. otherwise: if_id_instr <= mem_instruction; if_id_pc <= pc; if_id_pc_plus4 <= pc+4; if_id_valid <= 1; pc <= pc+4.
  - Redirect rules:
    - Redirects override stall. The squashed IF/ID contents (instr and pc) may retain stale values; only valid is cleared.
    - If the selected redirect target has bits[1:0] != 0: pc <= target & ~3, fetch_fault <= 1, go to FAULT. The exception vector is always aligned.
  - FAULT: terminal until reset. if_id_valid=0; pc, epc and IF/ID held; all inputs ignored.
- Wrap: pc 0xFFFF_FFFC advances to 0x0000_0000, with no fault.
- Simultaneous exc_valid + eret_valid: exception wins; epc is overwritten. Eret with a misaligned epc faults.

Decomposition:
- Shared package / mips.h additions: state encoding (FETCH_BOOT, FETCH_RUN, FETCH_FAULT), IVT_BASE default, cause width constant.
- One sub-module, next_pc_sel: combinational priority mux producing next pc, squash, misalign and epc-write enables.
- The top level holds the state register, pc, epc and the IF/ID register.

Test Plan:
- Boot: reset_n low 2 cycles, start_addr=0x0040_0000, release → cycle 1 fetch_addr=0, if_id_valid=0; cycle 2 fetch_addr=0x0040_0000; next edge if_id_pc=0x0040_0000, if_id_valid=1, fetch_addr=0x0040_0004.
- Sequential + stall: 3 free cycles then stall 2 cycles → fetch_addr holds 0x0040_000C, if_id_pc holds 0x0040_0008 with valid=1; release resumes at 0x0040_000C.
- Branch during stall: stall=1, branch_valid=1, target=0x0040_0100 → next fetch_addr=0x0040_0100, if_id_valid=0; following edge if_id_pc=0x0040_0100.
- Exception priority: exc_valid+branch_valid+eret_valid same cycle, cause=3, exc_pc=0x0040_0020 → fetch_addr=IVT_BASE+0xC, epc=0x0040_0020. A later eret → fetch_addr=0x0040_0020.
- Misaligned branch target 0x0040_0102 → fetch_fault=1, fetch_addr=0x0040_0100, if_id_valid stays 0 despite further branches. Asserting reset_n low clears the fault and returns to BOOT.
- Wrap: branch to 0xFFFF_FFFC, one free cycle → fetch_addr=0, if_id_pc_plus4=0, fetch_fault=0.
